// File: rtl/mem_reinit_writer.sv
// Runtime re-initialiser: streams DEPTH_MEM words into a memory through its write port.
// Define REINIT_VERIFY_EN to add a readback pass that checks an XOR signature of the words.
module mem_reinit_writer #(
   parameter int unsigned WID_MEM   = 4092,
   parameter int unsigned DEPTH_MEM = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               s_valid_i,
   input  logic [WID_MEM-1:0] s_data_i,
   output logic               s_ready_o,
   output logic [31:0]        waddr_o,
   output logic [WID_MEM-1:0] din_o,
   output logic               we_o,
   output logic [31:0]        raddr_o,
   input  logic [WID_MEM-1:0] dout_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam int unsigned CW = $clog2(DEPTH_MEM) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH_MEM - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_FLUSH  = 3'd2;
   localparam logic [2:0] S_VERIFY = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               s_ready_q, s_ready_d;
   logic               we_q, we_d;
   logic [31:0]        waddr_q, waddr_d;
   logic [WID_MEM-1:0] din_q, din_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

`ifdef REINIT_VERIFY_EN
   logic [WID_MEM-1:0] sig_q, sig_d;
   logic [WID_MEM-1:0] rsig_q, rsig_d;
   logic [31:0]        raddr_q, raddr_d;
   logic               err_q, err_d;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;
`ifdef REINIT_VERIFY_EN
      sig_d   = sig_q;
      rsig_d  = rsig_q;
      raddr_d = raddr_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_WRITE;
               cnt_d   = '0;
`ifdef REINIT_VERIFY_EN
               sig_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_WRITE: begin
            if (s_valid_i && s_ready_q) begin
               we_d    = 1'b1;
               waddr_d = 32'(cnt_q);
               din_d   = s_data_i;
               cnt_d   = cnt_q + CW'(1);
`ifdef REINIT_VERIFY_EN
               sig_d   = sig_q ^ s_data_i;
`endif
               if (cnt_q == LAST) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
`ifdef REINIT_VERIFY_EN
            state_d = S_VERIFY;
            cnt_d   = '0;
            raddr_d = '0;
            rsig_d  = '0;
`else
            state_d = S_DONE;
`endif
         end
`ifdef REINIT_VERIFY_EN
         // dout lags raddr by one cycle, so the word for cnt-1 arrives while cnt is presented
         S_VERIFY: begin
            if (cnt_q != '0) rsig_d = rsig_q ^ dout_i;
            if (cnt_q == LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               raddr_d = 32'(cnt_q + CW'(1));
            end
         end
         S_CHECK: begin
            err_d   = ((rsig_q ^ dout_i) != sig_q);
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      s_ready_d = (state_d == S_WRITE);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_ready_q <= s_ready_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef REINIT_VERIFY_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_q   <= '0;
         rsig_q  <= '0;
         raddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         rsig_q  <= rsig_d;
         raddr_q <= raddr_d;
         err_q   <= err_d;
      end
   end

   assign raddr_o = raddr_q;
   assign err_o   = err_q;
`else
   // Read port is idle without the readback pass
   logic unused_dout;
   assign unused_dout = ^dout_i;
   assign raddr_o     = '0;
   assign err_o       = 1'b0;
`endif

   assign s_ready_o = s_ready_q;
   assign we_o      = we_q;
   assign waddr_o   = waddr_q;
   assign din_o     = din_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_mem_reinit_writer.sv
// Directed bench for mem_reinit_writer (WID_MEM=8, DEPTH_MEM=4) with a small memory model.
// Honours REINIT_VERIFY_EN the same way as the design.
module tb_mem_reinit_writer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic [31:0] waddr;
   logic [7:0]  din;
   logic        we;
   logic [31:0] raddr;
   logic [7:0]  dout;
   logic        busy;
   logic        done;
   logic        err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

`ifdef REINIT_VERIFY_EN
   localparam int EXP_LAT = 6;
`else
   localparam int EXP_LAT = 1;
`endif

   mem_reinit_writer #(.WID_MEM(8), .DEPTH_MEM(4)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .s_valid_i (s_valid),
      .s_data_i  (s_data),
      .s_ready_o (s_ready),
      .waddr_o   (waddr),
      .din_o     (din),
      .we_o      (we),
      .raddr_o   (raddr),
      .dout_i    (dout),
      .busy_o    (busy),
      .done_o    (done),
      .err_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model with optional corruption of word 2 on readback
   logic [7:0] mem [4];
   bit         corrupt = 1'b0;
   always @(posedge clk) begin
      if (we) mem[waddr[1:0]] <= din;
      dout <= mem[raddr[1:0]] ^ ((corrupt && raddr[1:0] == 2'd2) ? 8'h5A : 8'h00);
   end

   // Write/done log
   int wn, dn, cyc, done_cyc;
   int wa [16];
   int wd [16];
   int wc [16];
   always @(posedge clk) begin
      cyc++;
      if (we && wn < 16) begin
         wa[wn] = int'(waddr);
         wd[wn] = int'(din);
         wc[wn] = cyc;
         wn++;
      end
      if (done) begin
         dn++;
         done_cyc = cyc;
      end
   end

   task automatic clear_log;
      wn = 0;
      dn = 0;
   endtask

   task automatic do_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic stream(input logic [31:0] words, input bit bub, input int first, input int last);
      int idx;
      int guard;
      bit tog;
      bit xfer;
      idx = first;
      guard = 0;
      tog = 1'b0;
      while (idx < last && guard < 40) begin
         if (bub && tog) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = words[8*idx +: 8];
         end
         tog  = ~tog;
         xfer = s_valid && s_ready;
         @(negedge clk);
         if (xfer) idx++;
         guard++;
      end
      s_valid = 1'b0;
      chk_cnt++;
      if (idx != last) $display("FAIL stream_timeout: accepted up to %0d, required %0d", idx, last);
      else pass_cnt++;
   endtask

   task automatic wait_done(input bit exp_err);
      int guard;
      guard = 0;
      while (done !== 1'b1 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      chk_cnt++;
      if (done !== 1'b1) $display("FAIL done_timeout: done=%b, required 1", done);
      else pass_cnt++;
      chk_cnt++;
      if (err !== exp_err) $display("FAIL err_at_done: err=%b, required %b", err, exp_err);
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL busy_at_done: busy=%b, required 1", busy);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
      else pass_cnt++;
   endtask

   task automatic check_writes(input string name, input logic [31:0] words);
      chk_cnt++;
      if (wn !== 4) $display("FAIL %s_count: writes=%0d, required 4", name, wn);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         chk_cnt++;
         if (wa[i] !== i || wd[i] !== int'(words[8*i +: 8]) || mem[i] !== words[8*i +: 8])
            $display("FAIL %s_word%0d: addr=%0d data=%h mem=%h, required addr=%0d data=%h",
                     name, i, wa[i], wd[i], mem[i], i, words[8*i +: 8]);
         else pass_cnt++;
      end
      chk_cnt++;
      if (dn !== 1) $display("FAIL %s_done_pulses: count=%0d, required 1", name, dn);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (s_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
         $display("FAIL reset_flags: s_ready=%b we=%b busy=%b done=%b err=%b, required all 0",
                  s_ready, we, busy, done, err);
      else pass_cnt++;
      chk_cnt++;
      if (waddr !== 32'd0 || raddr !== 32'd0 || din !== 8'd0)
         $display("FAIL reset_regs: waddr=%0d raddr=%0d din=%h, required 0 0 00", waddr, raddr, din);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      clear_log();
      do_start();
      chk_cnt++;
      if (busy !== 1'b1 || s_ready !== 1'b1) $display("FAIL b2b_enter_write: busy=%b s_ready=%b, required 1 1", busy, s_ready);
      else pass_cnt++;
      stream(32'h44332211, 1'b0, 0, 4);
      wait_done(1'b0);
      check_writes("b2b", 32'h44332211);
      chk_cnt++;
      if (wc[3] - wc[0] !== 3) $display("FAIL b2b_consecutive: span=%0d cycles, required 3", wc[3] - wc[0]);
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc - wc[3] !== EXP_LAT) $display("FAIL b2b_latency: last write to done=%0d, required %0d", done_cyc - wc[3], EXP_LAT);
      else pass_cnt++;
   endtask

   task automatic test_bubbles;
      clear_log();
      do_start();
      stream(32'hD4C3B2A1, 1'b1, 0, 4);
      wait_done(1'b0);
      check_writes("bubbles", 32'hD4C3B2A1);
      for (int i = 0; i < 3; i++) begin
         chk_cnt++;
         if (wc[i+1] - wc[i] !== 2) $display("FAIL bubbles_gap%0d: gap=%0d, required 2", i, wc[i+1] - wc[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_busy_start;
      clear_log();
      do_start();
      stream(32'h78563412, 1'b0, 0, 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stream(32'h78563412, 1'b0, 2, 4);
      wait_done(1'b0);
      check_writes("busy_start", 32'h78563412);
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0 || wn !== 4) $display("FAIL busy_start_idle: busy=%b writes=%0d, required 0 4", busy, wn);
      else pass_cnt++;
   endtask

`ifdef REINIT_VERIFY_EN
   task automatic test_verify;
      clear_log();
      corrupt = 1'b1;
      do_start();
      stream(32'h0F0E0D0C, 1'b0, 0, 4);
      wait_done(1'b1);
      chk_cnt++;
      if (err !== 1'b1) $display("FAIL verify_sticky: err=%b, required 1", err);
      else pass_cnt++;
      corrupt = 1'b0;
      do_start();
      chk_cnt++;
      if (err !== 1'b0) $display("FAIL verify_clear_on_start: err=%b, required 0", err);
      else pass_cnt++;
      stream(32'h0F0E0D0C, 1'b0, 0, 4);
      wait_done(1'b0);
   endtask
`endif

   task automatic test_midop_reset;
      clear_log();
      do_start();
      stream(32'h99887766, 1'b0, 0, 2);
      chk_cnt++;
      if (we !== 1'b1 || waddr !== 32'd1) $display("FAIL midop_pre: we=%b waddr=%0d, required 1 1", we, waddr);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (we !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || waddr !== 32'd0)
         $display("FAIL midop_reset: we=%b busy=%b s_ready=%b waddr=%0d, required 0 0 0 0", we, busy, s_ready, waddr);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL midop_idle: busy=%b, required 0", busy);
      else pass_cnt++;
      clear_log();
      do_start();
      stream(32'hF0E1D2C3, 1'b0, 0, 4);
      wait_done(1'b0);
      check_writes("midop_restart", 32'hF0E1D2C3);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      wn = 0;
      dn = 0;
      cyc = 0;
      done_cyc = 0;
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_busy_start();
`ifdef REINIT_VERIFY_EN
      test_verify();
`endif
      test_midop_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
